// File: rtl/csi_cin_lane_packer_if.sv
// Lane-packer bus: multi-lane CSI input beats in, packed valid/ready words out,
// plus configuration and status. The packer uses the slave modport.
interface csi_cin_lane_packer_if #(
  parameter int P_CIN_DATA_WIDTH = 8,
  parameter int P_LANES          = 4,
  parameter int P_FIFO_DEPTH     = 8
);
  localparam int LW = (P_LANES > 1) ? $clog2(P_LANES) : 1;
  localparam int CW = $clog2(P_FIFO_DEPTH + 1);

  logic [LW-1:0]                       cfg_lane_log2;
  logic [P_LANES*P_CIN_DATA_WIDTH-1:0] in_data;
  logic                                in_valid;
  logic                                in_flush;
  logic [P_LANES*P_CIN_DATA_WIDTH-1:0] out_data;
  logic [P_LANES-1:0]                  out_keep;
  logic                                out_valid;
  logic                                out_ready;
  logic [CW-1:0]                       fifo_level;
  logic                                overflow;

  modport master (
    output cfg_lane_log2, in_data, in_valid, in_flush, out_ready,
    input  out_data, out_keep, out_valid, fifo_level, overflow
  );

  modport slave (
    input  cfg_lane_log2, in_data, in_valid, in_flush, out_ready,
    output out_data, out_keep, out_valid, fifo_level, overflow
  );
endinterface

// File: rtl/csi_cin_lane_packer.sv
// Packs 1..P_LANES active lane words per beat into full-width words, with flush
// of partial words, and buffers them in a FIFO towards the packet parser.
module csi_cin_lane_packer #(
  parameter int P_CIN_DATA_WIDTH = 8,
  parameter int P_LANES          = 4,
  parameter int P_FIFO_DEPTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  csi_cin_lane_packer_if.slave  bus
);
  localparam int W      = P_CIN_DATA_WIDTH;
  localparam int LW     = (P_LANES > 1) ? $clog2(P_LANES) : 1;
  localparam int CW     = $clog2(P_FIFO_DEPTH + 1);
  localparam int PW     = $clog2(P_FIFO_DEPTH);
  localparam int MAXLOG = $clog2(P_LANES);
  localparam int FW     = $clog2(P_LANES + 1);

  typedef logic [P_LANES-1:0][W-1:0] word_t;
  typedef logic [FW:0]               sum_t;

  typedef struct packed {
    word_t              data;
    logic [P_LANES-1:0] keep;
  } entry_t;

  // Packer state
  logic [FW-1:0] fill_q, fill_d;
  word_t         slot_q, slot_d, slot_next, lanes;
  logic [LW-1:0] lane_log2_q, cfg_clamped, lane_log2_eff;
  sum_t          a_lanes, fill_after;
  logic          complete, push;
  entry_t        push_entry;

  // FIFO state
  entry_t        mem [P_FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] level_q;
  logic          overflow_q;
  logic          full, empty, pop, accept;

  assign lanes = bus.in_data;

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cfg_clamped = bus.cfg_lane_log2;
    if ({{(32-LW){1'b0}}, bus.cfg_lane_log2} > 32'(MAXLOG))
      cfg_clamped = LW'(MAXLOG);

    // Lane count only changes at a word boundary so slots stay aligned.
    lane_log2_eff = (fill_q == '0) ? cfg_clamped : lane_log2_q;
    a_lanes       = sum_t'(1) << lane_log2_eff;
    fill_after    = bus.in_valid ? sum_t'(fill_q) + a_lanes : sum_t'(fill_q);
    complete      = bus.in_valid && (fill_after == sum_t'(P_LANES));
    push          = complete || (bus.in_flush && (fill_after != '0));

    for (int i = 0; i < P_LANES; i++) begin
      slot_next[i] = slot_q[i];
      for (int k = 0; k < P_LANES; k++) begin
        if (bus.in_valid && (sum_t'(k) < a_lanes) &&
            (sum_t'(fill_q) + sum_t'(k) == sum_t'(i)))
          slot_next[i] = lanes[k];
      end
    end

    push_entry.data = slot_next;
    for (int i = 0; i < P_LANES; i++)
      push_entry.keep[i] = sum_t'(i) < fill_after;

    // Clearing on push keeps unused slots of a later partial word at zero.
    fill_d = push ? '0 : fill_after[FW-1:0];
    slot_d = push ? '0 : slot_next;
  end

  assign full   = (level_q == CW'(P_FIFO_DEPTH));
  assign empty  = (level_q == '0);
  assign pop    = !empty && bus.out_ready;
  assign accept = push && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q      <= '0;
      slot_q      <= '0;
      lane_log2_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      slot_q      <= slot_d;
      lane_log2_q <= lane_log2_eff;
      if (accept) wptr_q <= wptr_q + PW'(1);
      if (pop)    rptr_q <= rptr_q + PW'(1);
      if (push && !accept) overflow_q <= 1'b1;
      case ({accept, pop})
        2'b10:   level_q <= level_q + CW'(1);
        2'b01:   level_q <= level_q - CW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; fifo_level alone says which
  // entries are live, and stale contents are masked off the outputs.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr_q] <= push_entry;
  end

  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? '0 : mem[rptr_q].data;
  assign bus.out_keep   = empty ? '0 : mem[rptr_q].keep;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_csi_cin_lane_packer.sv
// Directed bench for csi_cin_lane_packer: expected words go into a scoreboard
// queue at stimulus time, a monitor pops and compares them on every output pop.
module tb_csi_cin_lane_packer;
  localparam int W = 8;
  localparam int L = 4;
  localparam int D = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t head;

  always #5 clk = ~clk;

  csi_cin_lane_packer_if #(.P_CIN_DATA_WIDTH(W), .P_LANES(L), .P_FIFO_DEPTH(D)) bus ();

  csi_cin_lane_packer #(.P_CIN_DATA_WIDTH(W), .P_LANES(L), .P_FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k);
    exp_t e;
    e.data = d;
    e.keep = k;
    sb.push_back(e);
  endtask

  task automatic beat(input int cfg, input logic [31:0] d, input bit fl);
    bus.cfg_lane_log2 = 2'(cfg);
    bus.in_data       = d;
    bus.in_valid      = 1'b1;
    bus.in_flush      = fl;
    step();
    bus.in_valid      = 1'b0;
    bus.in_flush      = 1'b0;
    bus.in_data       = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && bus.fifo_level != '0; i++) step();
    check(name, 32'(bus.fifo_level), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_data"},  bus.out_data,       32'd0);
    check({tag, "_keep"},  32'(bus.out_keep),  32'd0);
    check({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
    check({tag, "_ovf"},   32'(bus.overflow),  32'd0);
  endtask

  // Async reset pulse launched mid-cycle; released on a falling edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  // Monitor: compare the head against the scoreboard on every pop.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h keep 0x%0h, expected none",
                     bus.out_data, bus.out_keep);
          end else begin
            head = sb.pop_front();
            check("out_data", bus.out_data, head.data);
            check("out_keep", 32'(bus.out_keep), 32'(head.keep));
          end
        end else if (!bus.out_valid) begin
          check("idle_data", bus.out_data, 32'd0);
          check("idle_keep", 32'(bus.out_keep), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.cfg_lane_log2 = '0;
    bus.in_data       = '0;
    bus.in_valid      = 1'b0;
    bus.in_flush      = 1'b0;
    bus.out_ready     = 1'b1;

    #1;
    check_reset_outputs("reset");
    #11;
    rst = 1'b0;
    step();

    // 4-lane mode: one beat is one word, visible one cycle later.
    push_exp(32'h44332211, 4'hF);
    beat(2, 32'h44332211, 1'b0);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_level", 32'(bus.fifo_level), 32'd1);
    step();
    check("t1_valid_after", 32'(bus.out_valid), 32'd0);
    check("t1_level_after", 32'(bus.fifo_level), 32'd0);

    // 1-lane mode with garbage on the ignored upper lanes.
    push_exp(32'hA4A3A2A1, 4'hF);
    beat(0, 32'hEEEEEEA1, 1'b0);
    beat(0, 32'hEEEEEEA2, 1'b0);
    beat(0, 32'hEEEEEEA3, 1'b0);
    check("t2_not_yet", 32'(bus.out_valid), 32'd0);
    beat(0, 32'hEEEEEEA4, 1'b0);
    check("t2_valid", 32'(bus.out_valid), 32'd1);
    step();

    // Lane count change while fill != 0 is ignored until the word completes.
    push_exp(32'hD4C3B2A1, 4'hF);
    beat(0, 32'h000000A1, 1'b0);
    beat(2, 32'h777777B2, 1'b0);
    beat(2, 32'h777777C3, 1'b0);
    beat(2, 32'h777777D4, 1'b0);
    check("latch_valid", 32'(bus.out_valid), 32'd1);
    push_exp(32'h88776655, 4'hF);
    beat(2, 32'h88776655, 1'b0);
    step();
    step();

    // Flush of a partial 2-lane word.
    beat(1, 32'hDEAD2211, 1'b0);
    check("t3_not_yet", 32'(bus.out_valid), 32'd0);
    push_exp(32'h00002211, 4'h3);
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    step();

    // Flush coinciding with a completing beat: exactly one full word.
    push_exp(32'h44332211, 4'hF);
    beat(1, 32'hBEEF2211, 1'b0);
    beat(1, 32'hCAFE4433, 1'b1);
    check("t4_valid", 32'(bus.out_valid), 32'd1);
    step();
    step();
    check("t4_no_extra", 32'(bus.out_valid), 32'd0);

    // Flush with an empty packer pushes nothing.
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    step();
    check("empty_flush", 32'(bus.out_valid), 32'd0);

    // Overflow: fifth word dropped, sticky flag, order kept on drain.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_exp(32'(i), 4'hF);
      beat(2, 32'(i), 1'b0);
    end
    check("t5_level_full", 32'(bus.fifo_level), 32'd4);
    check("t5_ovf_before", 32'(bus.overflow), 32'd0);
    beat(2, 32'h00000005, 1'b0);
    check("t5_level_drop", 32'(bus.fifo_level), 32'd4);
    check("t5_ovf_set", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    wait_drain("t5_drain");
    check("t5_ovf_sticky", 32'(bus.overflow), 32'd1);

    pulse_reset("ovf_clear");

    // Full FIFO plus simultaneous pop accepts the new word.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_exp(32'(i * 16), 4'hF);
      beat(2, 32'(i * 16), 1'b0);
    end
    check("t6_level_full", 32'(bus.fifo_level), 32'd4);
    bus.out_ready = 1'b1;
    push_exp(32'h00000050, 4'hF);
    beat(2, 32'h00000050, 1'b0);
    check("t6_level_same", 32'(bus.fifo_level), 32'd4);
    check("t6_ovf_clear", 32'(bus.overflow), 32'd0);
    wait_drain("t6_drain");

    // Reset mid-frame discards FIFO contents and the partial packer word.
    bus.out_ready = 1'b0;
    push_exp(32'h99999999, 4'hF);
    beat(2, 32'h99999999, 1'b0);
    beat(0, 32'h000000EE, 1'b0);
    beat(0, 32'h000000EF, 1'b0);
    check("t7_level_pre", 32'(bus.fifo_level), 32'd1);
    pulse_reset("midreset");
    bus.out_ready = 1'b1;
    step();
    check("t7_quiet", 32'(bus.out_valid), 32'd0);
    push_exp(32'h04030201, 4'hF);
    for (int i = 1; i <= 4; i++) beat(0, 32'(i), 1'b0);
    check("t7_valid", 32'(bus.out_valid), 32'd1);
    wait_drain("t7_drain");

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
